cplx_round_clip: RTL and testbench

CPLX_ROUND_CLIP -- requirements
Module: cplx_round_clip

---
 rtl/cplx_round_clip_if.sv | 26 ++
 rtl/cplx_round_clip.sv | 98 +++++++++
 tb/tb_cplx_round_clip.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cplx_round_clip_if.sv
// Stream bundle for cplx_round_clip: input beat, output beat and saturation counter access.
interface cplx_round_clip_if #(
  parameter int WIDTH_IN  = 48,
  parameter int WIDTH_OUT = 16
);
  logic [2*WIDTH_IN-1:0]  i_tdata;
  logic                   i_tlast;
  logic                   i_tvalid;
  logic                   i_tready;
  logic [2*WIDTH_OUT-1:0] o_tdata;
  logic                   o_tlast;
  logic                   o_tvalid;
  logic                   o_tready;
  logic                   sat_clear;
  logic [15:0]            sat_count;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready, sat_clear,
    input  i_tready, o_tdata, o_tlast, o_tvalid, sat_count
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready, sat_clear,
    output i_tready, o_tdata, o_tlast, o_tvalid, sat_count
  );
endinterface

// File: rtl/cplx_round_clip.sv
// Complex I/Q round-half-up, shift and clip; 2-stage elastic pipeline, latency 2, full throughput.
// Saturated-beat counter built only when CPLX_ROUND_CLIP_SAT_CNT_EN is defined.
module cplx_round_clip #(
  parameter int WIDTH_IN  = 48,
  parameter int WIDTH_OUT = 16,
  parameter int DROP_LSB  = 15
) (
  input logic clk,
  input logic reset,
  cplx_round_clip_if.slave bus
);
  localparam int SW = WIDTH_IN + 1 - DROP_LSB;
  // Half an output LSB; shifting a one up then back down yields zero when nothing is dropped.
  localparam logic [WIDTH_IN:0] RND = ({{WIDTH_IN{1'b0}}, 1'b1} << DROP_LSB) >> 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  function automatic logic signed [SW-1:0] round_shift(input logic [WIDTH_IN-1:0] x);
    logic [WIDTH_IN:0] s;
    s = {x[WIDTH_IN-1], x} + RND;
    return s[WIDTH_IN:DROP_LSB];
  endfunction

  function automatic logic [WIDTH_OUT-1:0] clip(input logic signed [SW-1:0] v);
    if (v > MAXV)      return MAXV[WIDTH_OUT-1:0];
    else if (v < MINV) return MINV[WIDTH_OUT-1:0];
    else               return v[WIDTH_OUT-1:0];
  endfunction

  function automatic logic ovf(input logic signed [SW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  logic                   s1_vld, s1_last;
  logic signed [SW-1:0]   s1_i, s1_q;
  logic                   s2_vld, s2_last;
  logic [2*WIDTH_OUT-1:0] s2_dat;
  logic                   s1_rdy, s2_rdy;

  assign s2_rdy       = ~s2_vld | bus.o_tready;
  assign s1_rdy       = ~s1_vld | s2_rdy;
  assign bus.i_tready = s1_rdy;
  assign bus.o_tvalid = s2_vld;
  assign bus.o_tdata  = s2_dat;
  assign bus.o_tlast  = s2_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_i    <= '0;
      s1_q    <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_dat  <= '0;
    end else begin
      if (s1_rdy) s1_vld <= bus.i_tvalid;
      if (s1_rdy && bus.i_tvalid) begin
        s1_i    <= round_shift(bus.i_tdata[2*WIDTH_IN-1:WIDTH_IN]);
        s1_q    <= round_shift(bus.i_tdata[WIDTH_IN-1:0]);
        s1_last <= bus.i_tlast;
      end
      if (s2_rdy) s2_vld <= s1_vld;
      if (s2_rdy && s1_vld) begin
        s2_dat  <= {clip(s1_i), clip(s1_q)};
        s2_last <= s1_last;
      end
    end
  end

`ifdef CPLX_ROUND_CLIP_SAT_CNT_EN
  logic        s2_sat;
  logic [15:0] sat_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sat <= 1'b0;
    end else if (s2_rdy && s1_vld) begin
      s2_sat <= ovf(s1_i) | ovf(s1_q);
    end
  end

  // Clear takes priority over a coincident counting handshake.
  always_ff @(posedge clk) begin
    if (reset || bus.sat_clear) begin
      sat_cnt <= '0;
    end else if (s2_vld && bus.o_tready && s2_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign bus.sat_count = sat_cnt;
`else
  logic sat_clear_unused;
  assign sat_clear_unused = bus.sat_clear;
  assign bus.sat_count    = '0;
`endif
endmodule

// File: tb/tb_cplx_round_clip.sv
// Scoreboard bench for cplx_round_clip (WIDTH_IN=48, WIDTH_OUT=16, DROP_LSB=15).
module tb_cplx_round_clip;
  typedef struct packed {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cplx_round_clip_if #(.WIDTH_IN(48), .WIDTH_OUT(16)) bus ();
  cplx_round_clip #(.WIDTH_IN(48), .WIDTH_OUT(16), .DROP_LSB(15)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  bit rand_rdy = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic held_vld = 1'b0;
  logic [31:0] held_dat;
  logic held_last;

  // Reference: round half up at bit 14, arithmetic shift by 15, clip to 16 bits; bit 16 flags a clip.
  function automatic logic [16:0] model(input logic [47:0] v);
    longint x, r;
    x = longint'($signed(v));
    r = (x + 64'sd16384) >>> 15;
    if (r > 64'sd32767)  return {1'b1, 16'h7FFF};
    if (r < -64'sd32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.o_tready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: hold-stability while stalled, and in-order scoreboard on every handshake.
  always @(negedge clk) begin
    if (reset) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        checks++;
        if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== held_dat || bus.o_tlast !== held_last) begin
          errors++;
          $display("FAIL stall_hold: got vld=%b dat=%h last=%b expected vld=1 dat=%h last=%b",
                   bus.o_tvalid, bus.o_tdata, bus.o_tlast, held_dat, held_last);
        end
      end
      if (bus.o_tvalid === 1'b1 && bus.o_tready === 1'b1) begin
        checks++;
        rx_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got dat=%h last=%b expected no beat", bus.o_tdata, bus.o_tlast);
        end else begin
          mon_e = sb.pop_front();
          if (bus.o_tdata !== mon_e.dat || bus.o_tlast !== mon_e.last) begin
            errors++;
            $display("FAIL beat_data: got dat=%h last=%b expected dat=%h last=%b",
                     bus.o_tdata, bus.o_tlast, mon_e.dat, mon_e.last);
          end
        end
      end
      held_vld  = bus.o_tvalid && !bus.o_tready;
      held_dat  = bus.o_tdata;
      held_last = bus.o_tlast;
    end
  end

  task automatic send_beat(input longint i, input longint q, input logic last);
    logic [47:0] vi, vq;
    logic [16:0] mi, mq;
    logic rdy;
    vi = i[47:0];
    vq = q[47:0];
    bus.i_tdata  = {vi, vq};
    bus.i_tlast  = last;
    bus.i_tvalid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      rdy = bus.i_tready;
      @(posedge clk);
      #1;
      if (rdy) begin
        mi = model(vi);
        mq = model(vq);
        sb.push_back(exp_t'{dat: {mi[15:0], mq[15:0]}, last: last});
        bus.i_tvalid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got i_tready=0 for 1000 cycles expected acceptance");
    bus.i_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_tvalid = 1'b0;
    bus.i_tdata = '0;
    bus.i_tlast = 1'b0;
    bus.o_tready = 1'b1;
    bus.sat_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.o_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", bus.o_tvalid); end
    if (bus.o_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h expected 0", bus.o_tdata); end
    if (bus.o_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", bus.o_tlast); end
    if (bus.sat_count !== 16'h0) begin errors++; $display("FAIL rst_satcnt: got %h expected 0", bus.sat_count); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.i_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b expected 1", bus.i_tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    send_beat(64'h4000, 64'h3FFF, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b0) begin errors++; $display("FAIL lat_early: got vld=%b expected 0", bus.o_tvalid); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 32'h0001_0000 || bus.o_tlast !== 1'b1) begin
      errors++;
      $display("FAIL lat_beat: got vld=%b dat=%h last=%b expected vld=1 dat=00010000 last=1",
               bus.o_tvalid, bus.o_tdata, bus.o_tlast);
    end
    drain();
  endtask

  task automatic test_round();
    longint tbl_i[6];
    longint tbl_q[6];
    tbl_i = '{-64'sd16384, (64'sd32767 <<< 15) + 64'sd16383, (64'sd32767 <<< 15) + 64'sd16384,
              64'h7FFF_FFFF_FFFF, 64'sd49152, -64'sd49152};
    tbl_q = '{-64'sd16385, -(64'sd32768 <<< 15) - 64'sd16384, -(64'sd32768 <<< 15) - 64'sd16385,
              -64'sd140737488355328, -64'sd49153, 64'sd0};
    for (int n = 0; n < 6; n++) send_beat(tbl_i[n], tbl_q[n], n[0]);
    send_beat(-64'sd16384, -64'sd16385, 1'b0);
    drain();
    @(negedge clk);
    checks++;
    if (held_dat !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL round_neg_half: got %h expected 0000ffff", held_dat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sat();
`ifdef CPLX_ROUND_CLIP_SAT_CNT_EN
    bus.sat_clear = 1'b1;
    @(posedge clk);
    #1 bus.sat_clear = 1'b0;
    send_beat(64'sd1 <<< 40, -(64'sd1 <<< 40), 1'b0);
    @(negedge clk);
    checks++;
    if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_pre: got %h expected 0", bus.sat_count); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks += 2;
    if (bus.o_tdata !== 32'h7FFF_8000) begin errors++; $display("FAIL sat_data: got %h expected 7fff8000", bus.o_tdata); end
    if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_before_hs: got %h expected 0", bus.sat_count); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sat_count !== 16'd1) begin errors++; $display("FAIL sat_incr: got %h expected 1", bus.sat_count); end
    send_beat(64'sd100, -64'sd100, 1'b0);
    drain();
    checks++;
    if (bus.sat_count !== 16'd1) begin errors++; $display("FAIL sat_nocount: got %h expected 1", bus.sat_count); end
    bus.sat_clear = 1'b1;
    @(posedge clk);
    #1 bus.sat_clear = 1'b0;
    checks++;
    if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_clear: got %h expected 0", bus.sat_count); end
`else
    bus.sat_clear = 1'b1;
    send_beat(64'sd1 <<< 40, -(64'sd1 <<< 40), 1'b0);
    drain();
    bus.sat_clear = 1'b0;
    checks++;
    if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL sat_tied: got %h expected 0", bus.sat_count); end
`endif
  endtask

  task automatic test_stream();
    int rx_start;
    rx_start = rx_cnt;
    rand_rdy = 1;
    for (int b = 1; b <= 100; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat((longint'(b) <<< 15) + longint'(b * 211), -(longint'(b) <<< 15) - 64'sd16384, (b % 10) == 0);
    end
    drain();
    rand_rdy = 0;
    @(posedge clk);
    #2 bus.o_tready = 1'b1;
    checks++;
    if (rx_cnt - rx_start != 100) begin
      errors++;
      $display("FAIL stream_count: got %0d beats expected 100", rx_cnt - rx_start);
    end
  endtask

  task automatic test_stall_reset();
    int rx_start;
    bus.o_tready = 1'b0;
    send_beat(64'sd1 <<< 20, 64'sd5 <<< 15, 1'b0);
    send_beat(64'sd7 <<< 15, -(64'sd1 <<< 41), 1'b1);
    bus.i_tdata = {48'h1234_5678, 48'h0};
    bus.i_tvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.i_tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %b expected 0", bus.i_tready); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== sb[0].dat) begin
      errors++;
      $display("FAIL full_hold: got vld=%b dat=%h expected vld=1 dat=%h", bus.o_tvalid, bus.o_tdata, sb[0].dat);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.i_tvalid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checks += 2;
    if (bus.o_tvalid !== 1'b0) begin errors++; $display("FAIL post_rst_vld: got %b expected 0", bus.o_tvalid); end
    if (bus.sat_count !== 16'd0) begin errors++; $display("FAIL post_rst_cnt: got %h expected 0", bus.sat_count); end
    bus.o_tready = 1'b1;
    rx_start = rx_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (rx_cnt != rx_start) begin errors++; $display("FAIL stale_beats: got %0d expected 0", rx_cnt - rx_start); end
    @(posedge clk);
    #1;
  endtask

`ifdef CPLX_ROUND_CLIP_SAT_CNT_EN
  task automatic test_sat_full();
    for (int n = 0; n < 65535; n++) send_beat(64'sd1 <<< 31, 64'sd0, 1'b0);
    drain();
    checks++;
    if (bus.sat_count !== 16'hFFFF) begin errors++; $display("FAIL satfull_reach: got %h expected ffff", bus.sat_count); end
    send_beat(64'sd0, -(64'sd1 <<< 31), 1'b0);
    drain();
    checks++;
    if (bus.sat_count !== 16'hFFFF) begin errors++; $display("FAIL satfull_nowrap: got %h expected ffff", bus.sat_count); end
    send_beat(64'sd1 <<< 35, 64'sd0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_tvalid === 1'b1) break;
    end
    bus.sat_clear = 1'b1;
    @(posedge clk);
    #1 bus.sat_clear = 1'b0;
    checks += 2;
    if (sb.size() != 0) begin errors++; $display("FAIL satfull_hs: got %0d outstanding expected 0", sb.size()); end
    if (bus.sat_count !== 16'h0) begin errors++; $display("FAIL satfull_clear: got %h expected 0", bus.sat_count); end
  endtask
`endif

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_round();
    test_sat();
    test_stream();
    test_stall_reset();
`ifdef CPLX_ROUND_CLIP_SAT_CNT_EN
    test_sat_full();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
